// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NumReq requesters share one UART transmitter.
// Each transfer runs START -> BUSY -> DONE -> GAP. A start timeout aborts the transfer without an Ack.
module uart_tx_arbiter #(
    parameter int NumReq       = 4,
    parameter int ClksPerBit   = 5208,
    parameter int StartTimeout = 4 * ClksPerBit
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic [NumReq-1:0]     Req,
    input  logic [8*NumReq-1:0]   ReqData,
    output logic [NumReq-1:0]     Grant,
    output logic [NumReq-1:0]     Ack,
    output logic [7:0]            TxData,
    output logic                  TxSend,
    input  logic                  TxActive,
    input  logic                  TxDone,
    output logic                  Busy,
    output logic                  TimeoutErr
);

    localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int GapLen = ClksPerBit + 2;
    localparam int CntMax = (StartTimeout > GapLen) ? StartTimeout : GapLen;
    localparam int CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StBusy  = 3'd2,
        StDone  = 3'd3,
        StGap   = 3'd4
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [CntW-1:0]   cnt;
    logic [IdxW-1:0]   owner;
    logic [IdxW-1:0]   last;
    logic [IdxW-1:0]   winnerIdx;
    logic              winnerFound;
    logic              abortStart;
    logic [1:0]        activeSync;
    logic [1:0]        doneSync;
    logic              sActive;
    logic              sDone;
    logic [NumReq-1:0] grantR;
    logic [NumReq-1:0] ackR;
    logic [7:0]        txDataR;
    logic              txSendR;
    logic              busyR;
    logic              timeoutErrR;

    function automatic logic [NumReq-1:0] oneHot(input logic [IdxW-1:0] idx);
        logic [NumReq-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign sActive    = activeSync[1];
    assign sDone      = doneSync[1];
    assign Grant      = grantR;
    assign Ack        = ackR;
    assign TxData     = txDataR;
    assign TxSend     = txSendR;
    assign Busy       = busyR;
    assign TimeoutErr = timeoutErrR;

    // Bring the transmitter flags from the baud-clock domain into this clock domain.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            activeSync <= 2'b00;
            doneSync   <= 2'b00;
        end else begin
            activeSync <= {activeSync[0], TxActive};
            doneSync   <= {doneSync[0], TxDone};
        end
    end

    // Round-robin search: the first requester found after the last owner, wrapping around.
    always_comb begin
        int c;
        winnerFound = 1'b0;
        winnerIdx   = '0;
        c           = 0;
        for (int k = 1; k <= NumReq; k++) begin
            if (int'(last) + k < NumReq) begin
                c = int'(last) + k;
            end else begin
                c = int'(last) + k - NumReq;
            end
            if (!winnerFound && Req[IdxW'(c)]) begin
                winnerFound = 1'b1;
                winnerIdx   = IdxW'(c);
            end else begin
                winnerFound = winnerFound;
            end
        end
    end

    // Next-state logic for the transfer sequence.
    always_comb begin
        stateNext  = state;
        abortStart = 1'b0;
        case (state)
            StIdle: begin
                if (winnerFound) begin
                    stateNext = StStart;
                end else begin
                    stateNext = StIdle;
                end
            end
            StStart: begin
                if (sActive) begin
                    stateNext = StBusy;
                end else if (cnt == CntW'(StartTimeout - 1)) begin
                    stateNext  = StGap;
                    abortStart = 1'b1;
                end else begin
                    stateNext = StStart;
                end
            end
            StBusy: begin
                if (sDone && !sActive) begin
                    stateNext = StDone;
                end else begin
                    stateNext = StBusy;
                end
            end
            StDone: begin
                stateNext = StGap;
            end
            StGap: begin
                if (cnt == CntW'(GapLen - 1)) begin
                    stateNext = StIdle;
                end else begin
                    stateNext = StGap;
                end
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    // State, counter, and owner bookkeeping.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= StIdle;
            cnt     <= '0;
            owner   <= '0;
            last    <= IdxW'(NumReq - 1);
            txDataR <= 8'h00;
        end else begin
            state <= stateNext;
            if (stateNext != state) begin
                cnt <= '0;
            end else if (state == StStart || state == StGap) begin
                cnt <= cnt + CntW'(1);
            end else begin
                cnt <= cnt;
            end
            if (state == StIdle && winnerFound) begin
                owner   <= winnerIdx;
                txDataR <= ReqData[{winnerIdx, 3'b000} +: 8];
            end else begin
                owner   <= owner;
                txDataR <= txDataR;
            end
            if (state == StDone || abortStart) begin
                last <= owner;
            end else begin
                last <= last;
            end
        end
    end

    // Outputs are registered so that they line up with the state they belong to.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            grantR      <= '0;
            ackR        <= '0;
            txSendR     <= 1'b0;
            busyR       <= 1'b0;
            timeoutErrR <= 1'b0;
        end else begin
            if (state == StIdle && winnerFound) begin
                grantR <= oneHot(winnerIdx);
            end else if (stateNext == StDone || stateNext == StGap || stateNext == StIdle) begin
                grantR <= '0;
            end else begin
                grantR <= grantR;
            end
            if (stateNext == StDone) begin
                ackR <= oneHot(owner);
            end else begin
                ackR <= '0;
            end
            txSendR     <= (stateNext == StStart) || (stateNext == StBusy);
            busyR       <= (stateNext != StIdle);
            timeoutErrR <= abortStart;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized directed bench for uart_tx_arbiter with a behavioural transmitter and round-robin model.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int ST  = 4 * CPB;

    logic              Clock    = 1'b0;
    logic              ResetN   = 1'b1;
    logic [NR-1:0]     Req      = '0;
    logic [8*NR-1:0]   ReqData  = '0;
    logic [NR-1:0]     Grant;
    logic [NR-1:0]     Ack;
    logic [7:0]        TxData;
    logic              TxSend;
    logic              TxActive = 1'b0;
    logic              TxDone   = 1'b0;
    logic              Busy;
    logic              TimeoutErr;

    int errors  = 0;
    int checks  = 0;
    int expLast = NR - 1;
    bit txDead  = 1'b0;
    int phase   = 0;
    int txCnt   = 0;

    uart_tx_arbiter #(.NumReq(NR), .ClksPerBit(CPB), .StartTimeout(ST)) dut (
        .Clock(Clock), .ResetN(ResetN), .Req(Req), .ReqData(ReqData),
        .Grant(Grant), .Ack(Ack), .TxData(TxData), .TxSend(TxSend),
        .TxActive(TxActive), .TxDone(TxDone), .Busy(Busy), .TimeoutErr(TimeoutErr)
    );

    always #5 Clock = ~Clock;

    // Transmitter stand-in: answers Send with an active window, then a done flag.
    always @(posedge Clock) begin
        if (!ResetN || txDead) begin
            phase <= 0; txCnt <= 0; TxActive <= 1'b0; TxDone <= 1'b0;
        end else begin
            case (phase)
                0: if (TxSend) begin phase <= 1; txCnt <= 2; end
                1: if (txCnt == 0) begin TxActive <= 1'b1; txCnt <= $urandom_range(30, 10); phase <= 2; end
                   else txCnt <= txCnt - 1;
                2: if (txCnt == 0) begin TxActive <= 1'b0; TxDone <= 1'b1; txCnt <= 3; phase <= 3; end
                   else txCnt <= txCnt - 1;
                3: if (txCnt == 0) begin TxDone <= 1'b0; phase <= 4; end
                   else txCnt <= txCnt - 1;
                default: if (!TxSend) phase <= 0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int predictOwner(input logic [NR-1:0] r, input int lastOwner);
        for (int k = 1; k <= NR; k++) begin
            if (r[(lastOwner + k) % NR]) return (lastOwner + k) % NR;
        end
        return 0;
    endfunction

    task automatic serve(input bit expTimeout, input bit dropOnAck, input bit midChange);
        int          expOwner;
        logic [7:0]  expData;
        logic [31:0] oh;
        int          n;
        int          sendCycles;
        int          gapCycles;
        bit          done;
        bit          stableOk;
        bit          gapOk;
        expOwner = predictOwner(Req, expLast);
        expData  = ReqData[8*expOwner +: 8];
        oh       = 32'd1 << expOwner;
        n = 0;
        while (Grant === '0 && n < 500) begin @(negedge Clock); n++; end
        check("grant_onehot", 32'(Grant), oh);
        check("txdata_at_grant", 32'(TxData), 32'(expData));
        check("busy_at_grant", 32'(Busy), 32'd1);
        stableOk = 1'b1; sendCycles = 0; done = 1'b0; n = 0;
        while (!done && n < 2000) begin
            if (Ack !== '0 || TimeoutErr !== 1'b0) begin
                done = 1'b1;
            end else begin
                if (TxSend !== 1'b1 || TxData !== expData || 32'(Grant) !== oh) stableOk = 1'b0;
                sendCycles++;
                if (midChange && n == 12) begin
                    Req[expOwner] = 1'b0;
                    ReqData[8*expOwner +: 8] = ~expData;
                end
                @(negedge Clock); n++;
            end
        end
        check("transfer_ended", 32'(done), 32'd1);
        check("send_held_while_granted", 32'(stableOk), 32'd1);
        check("txdata_unchanged", 32'(TxData), 32'(expData));
        check("grant_cleared", 32'(Grant), 32'd0);
        check("txsend_low", 32'(TxSend), 32'd0);
        if (expTimeout) begin
            check("timeout_pulse", 32'(TimeoutErr), 32'd1);
            check("no_ack_on_abort", 32'(Ack), 32'd0);
            check("start_cycles", 32'(sendCycles), 32'(ST));
        end else begin
            check("ack_owner", 32'(Ack), oh);
            check("no_timeout", 32'(TimeoutErr), 32'd0);
            if (dropOnAck) Req[expOwner] = 1'b0;
            @(negedge Clock);
            check("ack_single_pulse", 32'(Ack), 32'd0);
        end
        gapCycles = 0; gapOk = 1'b1;
        while (Busy === 1'b1 && gapCycles < 100) begin
            if (TxSend !== 1'b0 || Ack !== '0) gapOk = 1'b0;
            if (gapCycles > 0 && TimeoutErr !== 1'b0) gapOk = 1'b0;
            gapCycles++;
            @(negedge Clock);
        end
        check("gap_quiet", 32'(gapOk), 32'd1);
        check("gap_len", 32'(gapCycles), 32'(CPB + 2));
        expLast = expOwner;
    endtask

    initial begin
        int n;
        #3 ResetN = 1'b0;
        #1;
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_txsend", 32'(TxSend), 32'd0);
        check("rst_txdata", 32'(TxData), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_timeout", 32'(TimeoutErr), 32'd0);
        repeat (3) @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);

        // All requesters held: strict rotation starting at 0.
        Req = 4'b1111; ReqData = $urandom;
        repeat (5) serve(1'b0, 1'b0, 1'b0);

        // Single requester with a known byte.
        Req = 4'b0001; ReqData = $urandom; ReqData[7:0] = 8'hA5;
        serve(1'b0, 1'b1, 1'b0);

        // Dead transmitter: abort, then the next requester in line.
        Req = 4'b0011; ReqData = $urandom; txDead = 1'b1;
        serve(1'b1, 1'b0, 1'b0);
        txDead = 1'b0;
        serve(1'b0, 1'b1, 1'b0);
        serve(1'b0, 1'b1, 1'b0);

        // Request and data withdrawn mid-transfer.
        Req = 4'b0100; ReqData = $urandom;
        serve(1'b0, 1'b1, 1'b1);

        // Random request mixes.
        for (int i = 0; i < 12; i++) begin
            Req = Req | 4'($urandom_range(15, 0));
            if (Req == 4'b0000) Req = 4'b1000;
            ReqData = $urandom;
            serve(1'b0, 1'b1, 1'b0);
        end

        // Reset in the middle of a transfer.
        Req = 4'b1111; ReqData = $urandom;
        n = 0;
        while (Grant === '0 && n < 500) begin @(negedge Clock); n++; end
        repeat (10) @(negedge Clock);
        check("pre_reset_sending", 32'(TxSend), 32'd1);
        #2 ResetN = 1'b0;
        #1;
        check("async_rst_txsend", 32'(TxSend), 32'd0);
        check("async_rst_grant", 32'(Grant), 32'd0);
        check("async_rst_busy", 32'(Busy), 32'd0);
        check("async_rst_ack", 32'(Ack), 32'd0);
        @(negedge Clock); @(negedge Clock);
        ResetN = 1'b1;
        expLast = NR - 1;
        serve(1'b0, 1'b1, 1'b0);
        Req = 4'b0000;
        repeat (5) @(negedge Clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
